// File: rtl/router_in_arbiter_if.sv
// Signal bundle between the three packet sources, the input arbiter and the router.
// The arbiter takes the slave view; the source/router side takes the master view.
interface router_in_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [2:0]        src_valid;
    logic [DATA_W-1:0] src_data_0;
    logic [DATA_W-1:0] src_data_1;
    logic [DATA_W-1:0] src_data_2;
    logic              busy;
    logic [2:0]        gnt;
    logic [2:0]        src_busy;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [2:0]        abort;

    modport slave (
        input  req, src_valid, src_data_0, src_data_1, src_data_2, busy,
        output gnt, src_busy, pkt_valid, data_in, abort
    );

    modport master (
        output req, src_valid, src_data_0, src_data_1, src_data_2, busy,
        input  gnt, src_busy, pkt_valid, data_in, abort
    );
endinterface

// File: rtl/router_in_arbiter.sv
// Packet-level round-robin arbiter sharing the router input port between three sources,
// with a beat-count watchdog that cuts runaway packets short.
module router_in_arbiter #(
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               clock,
    input  logic               resetn,
    router_in_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

    state_t            state_reg, state_next;
    logic [2:0]        gnt_reg, gnt_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [DATA_W-1:0] src_data    [3];
    logic [DATA_W-1:0] masked_data [3];
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic [1:0]        gnt_idx;
    logic [2:0]        rot_req;
    logic [2:0]        win_slot;
    logic [2:0]        pick;

    logic              pkt_valid_comb;
    logic [DATA_W-1:0] data_comb;
    logic [2:0]        src_busy_comb;
    logic [2:0]        abort_comb;

    assign src_data[0] = bus.src_data_0;
    assign src_data[1] = bus.src_data_1;
    assign src_data[2] = bus.src_data_2;

    // One-hot AND-OR mux driven straight from the registered grant.
    for (genvar gi = 0; gi < 3; gi++) begin : g_mux
        assign masked_data[gi] = gnt_reg[gi] ? src_data[gi] : '0;
    end

    assign sel_data  = masked_data[0] | masked_data[1] | masked_data[2];
    assign sel_valid = |(gnt_reg & bus.src_valid);
    assign gnt_idx   = gnt_reg[2] ? 2'd2 : (gnt_reg[1] ? 2'd1 : 2'd0);

    // Slot k holds the request of source (ptr+1+k) mod 3, so slot 0 has top priority.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rot
        localparam int OFS = gi + 1;
        assign rot_req[gi] = (ptr_reg == 2'd0) ? bus.req[OFS % 3] :
                             (ptr_reg == 2'd1) ? bus.req[(1 + OFS) % 3] :
                                                 bus.req[(2 + OFS) % 3];
    end

    assign win_slot = rot_req & (~rot_req + 3'd1);

    always_comb begin
        pick = win_slot;
        unique case (ptr_reg)
            2'd0:    pick = {win_slot[1:0], win_slot[2]};
            2'd1:    pick = {win_slot[0], win_slot[2:1]};
            default: pick = win_slot;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ptr_reg   <= 2'd2;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        pkt_valid_comb = 1'b0;
        data_comb      = '0;
        src_busy_comb  = 3'b111;
        abort_comb     = 3'b000;

        unique case (state_reg)
            IDLE: begin
                if ((|bus.req) && !bus.busy) begin
                    gnt_next   = pick;
                    cnt_next   = '0;
                    state_next = PASS;
                end
            end

            PASS: begin
                pkt_valid_comb = sel_valid;
                data_comb      = sel_data;
                src_busy_comb  = ~gnt_reg | {3{bus.busy}};
                if (!bus.busy) begin
                    if (!sel_valid) begin
                        ptr_next   = gnt_idx;
                        gnt_next   = '0;
                        state_next = DRAIN;
                    end else if (cnt_reg == CNT_MAX) begin
                        // Present this beat as parity so the router flags a parity error.
                        pkt_valid_comb = 1'b0;
                        abort_comb     = gnt_reg;
                        ptr_next       = gnt_idx;
                        gnt_next       = '0;
                        state_next     = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (!bus.busy) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced to their safe values combinationally while reset is held.
    assign bus.gnt       = gnt_reg;
    assign bus.src_busy  = resetn ? src_busy_comb : 3'b111;
    assign bus.pkt_valid = resetn & pkt_valid_comb;
    assign bus.data_in   = resetn ? data_comb : '0;
    assign bus.abort     = resetn ? abort_comb : 3'b000;
endmodule

// File: tb/tb_router_in_arbiter.sv
// Self-checking bench for router_in_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a packet-level scoreboard.
module tb_router_in_arbiter;
    localparam int DATA_W = 8;

    logic              clock = 1'b0;
    logic              resetn;
    logic [2:0]        req;
    logic [2:0]        src_valid;
    logic [DATA_W-1:0] src_data [3];
    logic              busy;

    always #5 clock = ~clock;

    router_in_arbiter_if #(.DATA_W(DATA_W)) bus_a ();
    router_in_arbiter_if #(.DATA_W(DATA_W)) bus_w ();

    assign bus_a.req        = req;
    assign bus_a.src_valid  = src_valid;
    assign bus_a.src_data_0 = src_data[0];
    assign bus_a.src_data_1 = src_data[1];
    assign bus_a.src_data_2 = src_data[2];
    assign bus_a.busy       = busy;
    assign bus_w.req        = req;
    assign bus_w.src_valid  = src_valid;
    assign bus_w.src_data_0 = src_data[0];
    assign bus_w.src_data_1 = src_data[1];
    assign bus_w.src_data_2 = src_data[2];
    assign bus_w.busy       = busy;

    router_in_arbiter #(.DATA_W(DATA_W), .MAX_PKT(64), .CNT_W(7)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus_a)
    );

    // Short watchdog instance; it sees the same stimulus as the main one.
    router_in_arbiter #(.DATA_W(DATA_W), .MAX_PKT(4), .CNT_W(3)) dut_wd (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [2:0] rq;
        logic [2:0] vl;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       bsy;
        logic [2:0] e_gnt;
        logic [2:0] e_sb;
        logic       e_pv;
        logic [7:0] e_data;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] vl,
                                input logic [7:0] d0, input logic [7:0] d1, input logic bs,
                                input logic [2:0] eg, input logic [2:0] esb, input logic epv,
                                input logic [7:0] ed);
        vec_t v;
        v.rst_n = r;  v.rq = rq;   v.vl = vl;     v.d0 = d0;  v.d1 = d1;
        v.bsy = bs;   v.e_gnt = eg; v.e_sb = esb; v.e_pv = epv; v.e_data = ed;
        return v;
    endfunction

    // ---------------- source engine and scoreboard ----------------
    logic       act    [3];
    logic       refill [3];
    int         nval   [3];
    int         pos    [3];
    logic [7:0] beats  [3][16];
    logic [7:0] cap    [$];
    logic [2:0] gnt_log [$];
    logic [2:0] prev_gnt, prev_req;
    logic [2:0] s_gnt, s_sb, s_abort;
    logic       s_pv;
    logic [7:0] s_din;
    int         rr_last, sent, done_pkts, stall_run, max_stall;
    logic       abort_seen;

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    function automatic int gidx(input logic [2:0] g);
        if (g[1]) return 1;
        if (g[2]) return 2;
        return 0;
    endfunction

    task automatic load_pkt(input int s, input int n);
        logic [7:0] par;
        par = 8'h00;
        for (int i = 0; i < n; i++) begin
            beats[s][i] = 8'($urandom);
            par ^= beats[s][i];
        end
        beats[s][n] = par;
        nval[s] = n;
        pos[s]  = 0;
        act[s]  = 1'b1;
        sent++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = 3'b000; src_valid = 3'b000; busy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            src_data[s] = '0; act[s] = 1'b0; refill[s] = 1'b0; nval[s] = 0; pos[s] = 0;
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn = 1'b1;
        prev_gnt = 3'b000; prev_req = 3'b000; rr_last = 2;
        stall_run = 0; max_stall = 0; abort_seen = 1'b0;
        cap.delete(); gnt_log.delete();
    endtask

    // One clock of the source engine; entered and left at posedge + 1.
    task automatic run_cycle(input logic busy_v);
        int         w;
        logic [2:0] e;
        logic       ok;
        for (int s = 0; s < 3; s++) begin
            req[s]       = act[s];
            src_valid[s] = act[s] && (pos[s] < nval[s]);
            src_data[s]  = act[s] ? beats[s][pos[s]] : 8'h00;
        end
        busy = busy_v;
        @(negedge clock);
        s_gnt = bus_a.gnt; s_sb = bus_a.src_busy; s_pv = bus_a.pkt_valid;
        s_din = bus_a.data_in; s_abort = bus_a.abort;

        if (s_gnt != 3'b000 && prev_gnt == 3'b000) begin
            w = rr_pick(prev_req, rr_last);
            e = (w >= 0) ? (3'b001 << w) : 3'b000;
            check("rr_grant", 32'(s_gnt), 32'(e));
            gnt_log.push_back(s_gnt);
            if (w >= 0) rr_last = w;
        end else if (s_gnt != 3'b000) begin
            check("gnt_stable", 32'(s_gnt), 32'(prev_gnt));
        end

        if (s_gnt != 3'b000 && !busy_v) begin
            cap.push_back(s_din);
            if (!s_pv) begin
                w  = gidx(s_gnt);
                ok = (cap.size() == nval[w] + 1);
                for (int i = 0; i < cap.size() && ok; i++) ok = (cap[i] == beats[w][i]);
                check($sformatf("pkt_src%0d", w), 32'(ok), 32'd1);
                $display("packet from source %0d: %0d beats delivered", w, cap.size());
                done_pkts++;
                cap.delete();
            end
        end

        if (s_abort != 3'b000) abort_seen = 1'b1;
        if ((|req) && s_gnt == 3'b000) stall_run++;
        else stall_run = 0;
        if (stall_run > max_stall) max_stall = stall_run;
        prev_gnt = s_gnt;
        prev_req = req;

        for (int s = 0; s < 3; s++) begin
            if (act[s] && !s_sb[s]) begin
                pos[s]++;
                if (pos[s] > nval[s]) begin
                    act[s] = 1'b0;
                    if (refill[s]) load_pkt(s, 2);
                end
            end
        end
        @(posedge clock); #1;
    endtask

    function automatic logic any_act();
        return act[0] | act[1] | act[2];
    endfunction

    logic [2:0] fair_exp [4];

    initial begin
        vecs[0]  = mk(0, 3'b000, 3'b000, 8'h00, 8'h00, 0, 3'b000, 3'b111, 0, 8'h00);
        vecs[1]  = mk(1, 3'b001, 3'b001, 8'h05, 8'h00, 0, 3'b000, 3'b111, 0, 8'h00);
        vecs[2]  = mk(1, 3'b001, 3'b001, 8'h05, 8'h00, 0, 3'b001, 3'b110, 1, 8'h05);
        vecs[3]  = mk(1, 3'b001, 3'b001, 8'h11, 8'h00, 1, 3'b001, 3'b111, 1, 8'h11);
        vecs[4]  = mk(1, 3'b001, 3'b001, 8'h11, 8'h00, 0, 3'b001, 3'b110, 1, 8'h11);
        vecs[5]  = mk(1, 3'b001, 3'b001, 8'h22, 8'h00, 0, 3'b001, 3'b110, 1, 8'h22);
        vecs[6]  = mk(1, 3'b001, 3'b001, 8'h33, 8'h00, 0, 3'b001, 3'b110, 1, 8'h33);
        vecs[7]  = mk(1, 3'b001, 3'b001, 8'h44, 8'h00, 0, 3'b001, 3'b110, 1, 8'h44);
        vecs[8]  = mk(1, 3'b001, 3'b001, 8'h55, 8'h00, 0, 3'b001, 3'b110, 1, 8'h55);
        vecs[9]  = mk(1, 3'b001, 3'b000, 8'h14, 8'h00, 0, 3'b001, 3'b110, 0, 8'h14);
        vecs[10] = mk(1, 3'b000, 3'b000, 8'h00, 8'h00, 1, 3'b000, 3'b111, 0, 8'h00);
        vecs[11] = mk(1, 3'b000, 3'b000, 8'h00, 8'h00, 1, 3'b000, 3'b111, 0, 8'h00);
        vecs[12] = mk(1, 3'b000, 3'b000, 8'h00, 8'h00, 0, 3'b000, 3'b111, 0, 8'h00);
        vecs[13] = mk(1, 3'b010, 3'b010, 8'h00, 8'h12, 0, 3'b000, 3'b111, 0, 8'h00);
        vecs[14] = mk(1, 3'b010, 3'b010, 8'h00, 8'h12, 0, 3'b010, 3'b101, 1, 8'h12);
        vecs[15] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA1, 0, 3'b010, 3'b101, 1, 8'hA1);
        vecs[16] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA2, 1, 3'b010, 3'b111, 1, 8'hA2);
        vecs[17] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA2, 1, 3'b010, 3'b111, 1, 8'hA2);
        vecs[18] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA2, 1, 3'b010, 3'b111, 1, 8'hA2);
        vecs[19] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA2, 1, 3'b010, 3'b111, 1, 8'hA2);
        vecs[20] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA2, 0, 3'b010, 3'b101, 1, 8'hA2);
        vecs[21] = mk(1, 3'b010, 3'b010, 8'h00, 8'hA3, 0, 3'b010, 3'b101, 1, 8'hA3);
        vecs[22] = mk(1, 3'b010, 3'b000, 8'h00, 8'hB2, 0, 3'b010, 3'b101, 0, 8'hB2);
        vecs[23] = mk(1, 3'b000, 3'b000, 8'h00, 8'h00, 0, 3'b000, 3'b111, 0, 8'h00);
        vecs[24] = mk(1, 3'b000, 3'b000, 8'h00, 8'h00, 0, 3'b000, 3'b111, 0, 8'h00);
        fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100; fair_exp[3] = 3'b001;
        sent = 0; done_pkts = 0;

        do_reset();

        // Directed table: single source 0 packet, then source 1 with a 4-cycle stall.
        for (int i = 0; i < NV; i++) begin
            resetn = vecs[i].rst_n; req = vecs[i].rq; src_valid = vecs[i].vl;
            src_data[0] = vecs[i].d0; src_data[1] = vecs[i].d1; src_data[2] = 8'h00;
            busy = vecs[i].bsy;
            @(negedge clock);
            checks++;
            if (bus_a.gnt !== vecs[i].e_gnt || bus_a.src_busy !== vecs[i].e_sb ||
                bus_a.pkt_valid !== vecs[i].e_pv || bus_a.data_in !== vecs[i].e_data) begin
                errors++;
                $display("FAIL vec%0d: got gnt=%b src_busy=%b pkt_valid=%b data_in=%h, expected gnt=%b src_busy=%b pkt_valid=%b data_in=%h",
                         i, bus_a.gnt, bus_a.src_busy, bus_a.pkt_valid, bus_a.data_in,
                         vecs[i].e_gnt, vecs[i].e_sb, vecs[i].e_pv, vecs[i].e_data);
            end else begin
                $display("vec %0d: gnt=%b src_busy=%b pkt_valid=%b data_in=%h",
                         i, bus_a.gnt, bus_a.src_busy, bus_a.pkt_valid, bus_a.data_in);
            end
            @(posedge clock); #1;
        end

        // Fairness: all three sources request back-to-back 3-beat packets.
        do_reset();
        for (int s = 0; s < 3; s++) begin
            refill[s] = 1'b1;
            load_pkt(s, 2);
        end
        for (int c = 0; c < 200 && gnt_log.size() < 4; c++) run_cycle(1'b0);
        check("fair_grant_count", 32'(gnt_log.size() >= 4), 32'd1);
        if (gnt_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("fair_gnt%0d", i), 32'(gnt_log[i]), 32'(fair_exp[i]));
        end
        for (int s = 0; s < 3; s++) refill[s] = 1'b0;
        for (int c = 0; c < 200 && any_act(); c++) run_cycle(1'b0);
        for (int c = 0; c < 3; c++) run_cycle(1'b0);

        // Source 1 alone, twice in a row: each request granted on the next cycle.
        for (int p = 0; p < 2; p++) begin
            load_pkt(1, 3);
            run_cycle(1'b0);
            check($sformatf("rereq%0d_idle", p), 32'(s_gnt), 32'd0);
            run_cycle(1'b0);
            check($sformatf("rereq%0d_gnt", p), 32'(s_gnt), 32'b010);
            for (int c = 0; c < 50 && any_act(); c++) run_cycle(1'b0);
            for (int c = 0; c < 3; c++) run_cycle(1'b0);
        end

        // Watchdog on the MAX_PKT=4 instance: source 0 never drops src_valid.
        do_reset();
        req = 3'b011; src_valid = 3'b011; src_data[0] = 8'hC0; src_data[1] = 8'hD0; busy = 1'b0;
        @(negedge clock);
        check("wd_idle_gnt", 32'(bus_w.gnt), 32'd0);
        for (int b = 1; b <= 5; b++) begin
            @(posedge clock); #1;
            src_data[0] = 8'hC0 + 8'(b);
            @(negedge clock);
            check($sformatf("wd_gnt_b%0d", b), 32'(bus_w.gnt), 32'b001);
            check($sformatf("wd_pv_b%0d", b), 32'(bus_w.pkt_valid), (b < 5) ? 32'd1 : 32'd0);
            check($sformatf("wd_abort_b%0d", b), 32'(bus_w.abort), (b < 5) ? 32'd0 : 32'b001);
            check($sformatf("wd_data_b%0d", b), 32'(bus_w.data_in), 32'(8'hC0 + 8'(b)));
        end
        @(posedge clock); #1;
        @(negedge clock);
        check("wd_drain_abort", 32'(bus_w.abort), 32'd0);
        check("wd_drain_gnt", 32'(bus_w.gnt), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("wd_idle2_gnt", 32'(bus_w.gnt), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("wd_next_gnt", 32'(bus_w.gnt), 32'b010);
        $display("watchdog sequence: abort and regrant observed");

        // Reset for one cycle in the middle of a source 2 packet.
        do_reset();
        req = 3'b100; src_valid = 3'b100; src_data[2] = 8'hE0; busy = 1'b0;
        @(negedge clock);
        check("rst_idle_gnt", 32'(bus_a.gnt), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_pass_gnt", 32'(bus_a.gnt), 32'b100);
        @(posedge clock); #1;
        src_data[2] = 8'hE1;
        @(negedge clock);
        check("rst_pass_pv", 32'(bus_a.pkt_valid), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b0; src_data[2] = 8'hE2;
        @(negedge clock);
        check("rst_hold_pv", 32'(bus_a.pkt_valid), 32'd0);
        check("rst_hold_sbusy", 32'(bus_a.src_busy), 32'b111);
        check("rst_hold_data", 32'(bus_a.data_in), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1; req = 3'b111; src_valid = 3'b111;
        @(negedge clock);
        check("rst_after_gnt", 32'(bus_a.gnt), 32'd0);
        check("rst_after_pv", 32'(bus_a.pkt_valid), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_regrant", 32'(bus_a.gnt), 32'b001);
        $display("reset sequence: regrant to source 0");

        // Randomized traffic with random router back-pressure.
        do_reset();
        sent = 0; done_pkts = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!act[s] && $urandom_range(7) == 0) load_pkt(s, int'($urandom_range(12, 1)));
            end
            run_cycle($urandom_range(3) == 0);
        end
        for (int c = 0; c < 600 && any_act(); c++) run_cycle($urandom_range(3) == 0);
        check("rand_drained", 32'(any_act()), 32'd0);
        check("rand_pkt_count", 32'(done_pkts), 32'(sent));
        check("rand_no_abort", 32'(abort_seen), 32'd0);
        check("rand_no_starve", 32'(max_stall <= 40), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
